dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 77 +++++++
 rtl/dmem_lane.sv | 18 +
 rtl/dmem_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: size encodings,
// FSM state codes and the byte-lane / sign-extension helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT   = 2'd0;
    localparam state_t ST_IDLE   = 2'd1;
    localparam state_t ST_P_WAIT = 2'd2;

    // True when the access cannot be performed at this offset (or size is illegal).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for an access of the given size at the given offset.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Moves right-aligned store data into the lanes it will occupy.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {24'b0, wdata[7:0]} << {off, 3'b000};
            SZ_HALF: d = off[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
            SZ_WORD: d = wdata;
            default: d = 32'b0;
        endcase
        return d;
    endfunction

    // Picks the addressed lane out of a word and sign- or zero-extends it.
    function automatic logic [31:0] lane_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: d = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: d = uns ? {16'b0, h} : {{16{h[15]}}, h};
            SZ_WORD: d = word;
            default: d = 32'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Load-path lane select and extension; shared by the RAM and peripheral
// read paths so both produce identically formatted results.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] data
);

    // Pure combinational extract-then-extend of the addressed lane.
    always_comb begin
        data = lane_load(word, size, off, uns);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: local word RAM with byte lanes, a zeroing sweep
// after reset, and a single-outstanding peripheral port with a timeout.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int PERIPH_BIT = 30,
    parameter int P_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        fault,
    output logic        stall,
    output logic        busy,
    output logic        p_req,
    output logic        p_we,
    output logic [3:0]  p_be,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    input  logic [31:0] p_rdata,
    input  logic        p_ack
);

    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int WAIT_W = $clog2(P_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(P_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  fault_q, fault_d;
    logic                  p_req_q, p_req_d;
    logic                  p_we_q, p_we_d;
    logic [3:0]            p_be_q, p_be_d;
    logic [31:0]           p_addr_q, p_addr_d;
    logic [31:0]           p_wdata_q, p_wdata_d;
    logic [1:0]            p_size_q, p_size_d;
    logic                  p_uns_q, p_uns_d;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [31:0]           mem_wdata;

    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  bad_access;
    logic                  to_periph;
    logic                  timed_out;
    logic                  unused_addr;

    logic [31:0]           lane_word;
    logic [1:0]            lane_size;
    logic [1:0]            lane_off;
    logic                  lane_uns;
    logic [31:0]           lane_data;

    assign ram_idx     = addr[DEPTH_LOG2+1:2];
    assign bad_access  = is_misaligned(size, addr[1:0]);
    assign to_periph   = addr[PERIPH_BIT];
    assign timed_out   = (wait_cnt_q == WAIT_LAST);
    assign unused_addr = ^addr;

    assign stall   = (state_q != ST_IDLE);
    assign busy    = (state_q == ST_INIT);
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign fault   = fault_q;
    assign p_req   = p_req_q;
    assign p_we    = p_we_q;
    assign p_be    = p_be_q;
    assign p_addr  = p_addr_q;
    assign p_wdata = p_wdata_q;

    // Feed the shared lane unit from the peripheral while waiting, else from the RAM.
    always_comb begin
        if (state_q == ST_P_WAIT) begin
            lane_word = p_rdata;
            lane_size = p_size_q;
            lane_off  = p_addr_q[1:0];
            lane_uns  = p_uns_q;
        end else begin
            lane_word = mem[ram_idx];
            lane_size = size;
            lane_off  = addr[1:0];
            lane_uns  = uns;
        end
    end

    dmem_lane u_lane (
        .word (lane_word),
        .size (lane_size),
        .off  (lane_off),
        .uns  (lane_uns),
        .data (lane_data)
    );

    // Next-state logic: init sweep, request decode, and peripheral handshake.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        fault_d    = 1'b0;
        p_req_d    = p_req_q;
        p_we_d     = p_we_q;
        p_be_d     = p_be_q;
        p_addr_d   = p_addr_q;
        p_wdata_d  = p_wdata_q;
        p_size_d   = p_size_q;
        p_uns_d    = p_uns_q;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_idx    = ram_idx;
        mem_wdata  = lane_wdata(size, addr[1:0], wdata);

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_be     = 4'b1111;
                mem_idx    = init_cnt_q;
                mem_wdata  = 32'b0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {DEPTH_LOG2{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (req) begin
                    if (bad_access) begin
                        fault_d = 1'b1;
                    end else if (to_periph) begin
                        state_d    = ST_P_WAIT;
                        wait_cnt_d = '0;
                        p_req_d    = 1'b1;
                        p_we_d     = we;
                        p_be_d     = lane_be(size, addr[1:0]);
                        p_addr_d   = addr;
                        p_wdata_d  = lane_wdata(size, addr[1:0], wdata);
                        p_size_d   = size;
                        p_uns_d    = uns;
                    end else if (we) begin
                        mem_we = 1'b1;
                        mem_be = lane_be(size, addr[1:0]);
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = lane_data;
                    end
                end
            end

            ST_P_WAIT: begin
                if (p_ack) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    p_req_d    = 1'b0;
                    p_we_d     = 1'b0;
                    p_be_d     = 4'b0000;
                    if (!p_we_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = lane_data;
                    end
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    fault_d    = 1'b1;
                    p_req_d    = 1'b0;
                    p_we_d     = 1'b0;
                    p_be_d     = 4'b0000;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Controller state registers; reset restarts the sweep and clears the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= 32'b0;
            rvalid_q   <= 1'b0;
            fault_q    <= 1'b0;
            p_req_q    <= 1'b0;
            p_we_q     <= 1'b0;
            p_be_q     <= 4'b0000;
            p_addr_q   <= 32'b0;
            p_wdata_q  <= 32'b0;
            p_size_q   <= 2'b00;
            p_uns_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            fault_q    <= fault_d;
            p_req_q    <= p_req_d;
            p_we_q     <= p_we_d;
            p_be_q     <= p_be_d;
            p_addr_q   <= p_addr_d;
            p_wdata_q  <= p_wdata_d;
            p_size_q   <= p_size_d;
            p_uns_q    <= p_uns_d;
        end
    end

    // RAM array is deliberately unreset; only the sweep clears it, and writes are held off while in reset.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
